// File: rtl/mem_dump_reader.sv
// Purpose : streams a block of 32-bit big-endian words out of a byte-wide memory read port.
// Latency : first word valid 5 cycles after start; 6 cycles per word with the consumer always ready.
// Backpressure: out_ready low parks the engine in OUT with word/address held and no memory reads.
//
// Ports:
//   clk, reset               - clock, asynchronous active-high reset
//   start, base_addr,        - dump request (sampled only when idle); base is word-aligned internally
//   word_count
//   mem_rd_en, mem_addr,     - byte read port; mem_rdata returns one cycle after mem_rd_en
//   mem_rdata
//   out_valid, out_ready,    - assembled word stream (valid/ready)
//   out_data, out_addr
//   busy, done               - status: busy while dumping, one-cycle done pulse at the end
module mem_dump_reader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    output logic                  mem_rd_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [7:0]            mem_rdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LAST  = 3'd2;
    localparam logic [2:0] S_OUT   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic [1:0]            k_q, k_d;
    logic [31:0]           asm_q, asm_d;
    logic [31:0]           data_q, data_d;
    logic [ADDR_WIDTH-1:0] oaddr_q, oaddr_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        k_d     = k_q;
        asm_d   = asm_q;
        data_d  = data_q;
        oaddr_d = oaddr_q;
        busy_d  = busy_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        ptr_d   = {base_addr[ADDR_WIDTH-1:2], 2'b00};
                        cnt_d   = word_count;
                        k_d     = 2'd0;
                        busy_d  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        // Empty dump: pulse done without ever raising busy.
                        state_d = S_DONE;
                    end
                end
            end
            S_FETCH: begin
                // The byte shifted in on the first FETCH edge is stale; it
                // falls off the top by the time the word is complete.
                asm_d = {asm_q[23:0], mem_rdata};
                k_d   = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    state_d = S_LAST;
                end
            end
            S_LAST: begin
                data_d  = {asm_q[23:0], mem_rdata};
                oaddr_d = ptr_q;
                state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    cnt_d = cnt_q - 1'b1;
                    ptr_d = ptr_q + WORD_STEP;
                    // k has already wrapped back to 0 after the fourth fetch.
                    state_d = (cnt_q == ADDR_WIDTH'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            k_q     <= 2'd0;
            asm_q   <= '0;
            data_q  <= '0;
            oaddr_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            oaddr_q <= oaddr_d;
            busy_q  <= busy_d;
        end
    end

    // Outputs come from registers or a state decode only.
    assign mem_rd_en = (state_q == S_FETCH);
    assign mem_addr  = mem_rd_en ? (ptr_q + {{(ADDR_WIDTH-2){1'b0}}, k_q}) : '0;
    assign out_valid = (state_q == S_OUT);
    assign out_data  = data_q;
    assign out_addr  = oaddr_q;
    assign busy      = busy_q;
    assign done      = (state_q == S_DONE);

endmodule

// File: doc/mem_dump_reader.md
# mem_dump_reader

Read-back engine for the processor's byte-addressed, big-endian memories: the read-side counterpart of the bench's preload writes. On a start request it streams a block of 32-bit words out of a byte-wide memory read port. Each word is assembled from four consecutive bytes, MSB first, and presented on a valid/ready output stream. It sits beside `data_mem` (or `my_ins_mem`) as a debug/verification dump port and never writes memory.

## Interface
- `ADDR_WIDTH`, default 8: byte address width. All address arithmetic is modulo 2^ADDR_WIDTH.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `start` in 1: one-cycle request, sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: byte address of the first word, sampled with `start`. Low 2 bits are forced to 00 internally.
- `word_count` in ADDR_WIDTH: number of words to dump, sampled with `start`.
- `mem_rd_en` out 1: byte read strobe.
- `mem_addr` out ADDR_WIDTH: byte read address.
- `mem_rdata` in 8: byte returned exactly 1 cycle after the `mem_rd_en` cycle.
- `out_valid` out 1: assembled word available.
- `out_ready` in 1: consumer accepts the word.
- `out_data` out 32: assembled word. `mem[a]` goes to [31:24] and `mem[a+3]` goes to [7:0].
- `out_addr` out ADDR_WIDTH: byte address of the word in `out_data`.
- `busy` out 1: high from the cycle after an accepted start until `done`.
- `done` out 1: one-cycle pulse when the dump completes.

## Operation
- States: IDLE, FETCH, LAST, OUT, DONE.
- **IDLE**
  - `start`=1 and `word_count`≠0: latch base/count, set word pointer = base, byte index k = 0, go to FETCH.
  - `start`=1 and `word_count`=0: go to DONE. No reads are issued.
- **FETCH** (exactly 4 cycles)
  - Drive `mem_rd_en`=1 and `mem_addr`=ptr+k for k=0..3.
  - Each cycle, shift the previous cycle's `mem_rdata` into the assembly register.
  - After k=3, go to LAST.
- **LAST** (1 cycle)
  - `mem_rd_en`=0.
  - Capture byte 3, load `out_data` and `out_addr`=ptr, go to OUT.
- **OUT**
  - `out_valid`=1. `out_data` and `out_addr` are held stable until `out_ready`=1 at a rising edge.
  - On transfer: decrement remaining count, ptr += 4.
  - Remaining count ≠ 0: go to FETCH with k=0. Otherwise go to DONE.
- **DONE**
  - `done`=1 for one cycle, `busy` falls, go to IDLE.
- `start` is ignored in every state except IDLE. The latched base/count are unaffected.
- Address wrap: ptr+k and ptr+4 wrap modulo 2^ADDR_WIDTH with no error flag.
- Reset mid-operation: immediate return to IDLE. No `done` pulse, the partial word is discarded, `out_valid` drops asynchronously.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `busy`=0, `done`=0.
- All outputs are registered or decoded from state only. No combinational path from `out_ready` or `mem_rdata` to any output.
- Start sampled at edge E0:
  - Reads issued in the cycles after E0..E3.
  - LAST runs after E4.
  - `out_valid` is high after E5 (5-cycle latency).
- Per-word cost: 5 cycles plus OUT residency. With `out_ready` held high, each word costs 6 cycles.
- Single word with `out_ready` high: transfer at E6, `done` high after E6, `busy` low after E7.
- `word_count`=0: `done` high in the cycle after E0. `busy` is never asserted.
- Backpressure: OUT may last any number of cycles. No memory reads occur while in OUT.

## Test plan
- Memory bytes 4..7 = {00,00,00,28}, base=4, count=1, `out_ready`=1 → `out_data`=0x00000028, `out_addr`=4, `out_valid` first high 5 cycles after start, one `done` pulse.
- Memory bytes 0..7 = {00,00,00,00,00,00,00,28}, base=0, count=2 → words 0x00000000 @0, then 0x00000028 @4. `mem_addr` sequence 0,1,2,3,4,5,6,7. 12 cycles from start to transfer of the last word.
- Backpressure: `out_ready`=0 for 7 cycles during OUT → `out_data`/`out_addr` stable, no `mem_rd_en` pulses, transfer on the first ready cycle.
- Wrap: ADDR_WIDTH=8, base=0xFC, count=2, bytes FC..FF = {DE,AD,BE,EF}, 00..03 = {01,02,03,04} → 0xDEADBEEF @0xFC, then 0x01020304 @0x00.
- `word_count`=0 → `done` pulse the next cycle, `busy`=0 throughout, zero reads. A second `start` while busy has no effect on the running count.
- Reset asserted during FETCH of word 1 → all outputs at reset values immediately, no `done`. A new start afterwards dumps correctly.
